// File: rtl/ycbcr2rgb_ctrl.sv
// rtl/ycbcr2rgb_ctrl.sv - frame-synchronous mode controller around a fixed-latency YCbCr-to-RGB converter
module ycbcr2rgb_ctrl #(
    parameter int   H_ACTIVE = 1280,
    parameter int   V_ACTIVE = 720,
    parameter int   BAR_W    = 160,
    parameter logic VS_POL   = 1'b1,
    parameter int   CSC_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_y_8b,
    input  logic [7:0]  i_cb_8b,
    input  logic [7:0]  i_cr_8b,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic        i_data_en,
    input  logic [1:0]  cfg_mode,
    input  logic        err_clr,
    output logic [7:0]  csc_y_8b,
    output logic [7:0]  csc_cb_8b,
    output logic [7:0]  csc_cr_8b,
    input  logic [7:0]  csc_r_8b,
    input  logic [7:0]  csc_g_8b,
    input  logic [7:0]  csc_b_8b,
    output logic [7:0]  o_r_8b,
    output logic [7:0]  o_g_8b,
    output logic [7:0]  o_b_8b,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_data_en,
    output logic [1:0]  o_mode_active,
    output logic [15:0] o_frame_cnt,
    output logic        o_line_err,
    output logic        o_frame_err
);

    localparam logic [10:0] H_PIX    = 11'(H_ACTIVE);
    localparam logic [10:0] V_LINES  = 11'(V_ACTIVE);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;

    typedef enum logic {WAIT_VS, RUN} state_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [2:0] bar;
        logic       hs;
        logic       vs;
        logic       de;
        logic [1:0] mode;
        logic       run;
    } tap_t;

    state_t      state_q, state_d;
    logic        vs_prev_q, vs_prev_d;
    logic        de_prev_q, de_prev_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [10:0] x_cnt_q, x_cnt_d;
    logic [10:0] y_cnt_q, y_cnt_d;
    logic [10:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    tap_t        pipe_q [CSC_LAT];
    tap_t        pipe_d [CSC_LAT];
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;

    logic        vs_edge;
    logic        de_fall;
    logic        line_set;
    logic        frame_set;
    tap_t        tap;

    assign csc_y_8b  = i_y_8b;
    assign csc_cb_8b = i_cb_8b;
    assign csc_cr_8b = i_cr_8b;

    always_comb begin
        vs_edge     = (i_v_sync == VS_POL) && (vs_prev_q != VS_POL);
        de_fall     = de_prev_q && !i_data_en;
        state_d     = state_q;
        vs_prev_d   = i_v_sync;
        de_prev_d   = i_data_en;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;

        // Line checks only once locked: a reset mid-line must not report a short line.
        line_set  = de_fall && (state_q == RUN) && (x_cnt_q != H_PIX);
        frame_set = vs_edge && (state_q == RUN) && (y_cnt_q != V_LINES);

        if (de_fall) begin
            x_cnt_d = '0;
        end else if (i_data_en && (x_cnt_q != CNT_MAX)) begin
            x_cnt_d = x_cnt_q + 11'd1;
        end

        if (vs_edge) begin
            y_cnt_d = '0;
        end else if (de_fall && (y_cnt_q != CNT_MAX)) begin
            y_cnt_d = y_cnt_q + 11'd1;
        end

        if (!i_data_en) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            if (bar_idx_q != 3'd7) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end
        end else begin
            bar_cnt_d = bar_cnt_q + 11'd1;
        end

        case (state_q)
            WAIT_VS: begin
                if (vs_edge) begin
                    state_d = RUN;
                    mode_d  = cfg_mode;
                end
            end
            RUN: begin
                if (vs_edge) begin
                    mode_d      = cfg_mode;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = WAIT_VS;
        endcase

        line_err_d  = line_set  ? 1'b1 : (err_clr ? 1'b0 : line_err_q);
        frame_err_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);

        pipe_d[0].y    = i_y_8b;
        pipe_d[0].cb   = i_cb_8b;
        pipe_d[0].cr   = i_cr_8b;
        pipe_d[0].bar  = bar_idx_q;
        pipe_d[0].hs   = i_h_sync;
        pipe_d[0].vs   = i_v_sync;
        pipe_d[0].de   = i_data_en;
        pipe_d[0].mode = mode_q;
        pipe_d[0].run  = (state_q == RUN);
        for (int i = 1; i < CSC_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        // The last tap lines up with the converter result for the same input pixel.
        tap   = pipe_q[CSC_LAT-1];
        rgb_d = '0;
        if (tap.run && tap.de) begin
            case (tap.mode)
                2'd0: rgb_d = {csc_r_8b, csc_g_8b, csc_b_8b};
                2'd1: rgb_d = {tap.y, tap.cb, tap.cr};
                2'd2: rgb_d = {tap.y, tap.y, tap.y};
                default: begin
                    case (tap.bar)
                        3'd0: rgb_d = 24'hFFFFFF;
                        3'd1: rgb_d = 24'hFFFF00;
                        3'd2: rgb_d = 24'h00FFFF;
                        3'd3: rgb_d = 24'h00FF00;
                        3'd4: rgb_d = 24'hFF00FF;
                        3'd5: rgb_d = 24'hFF0000;
                        3'd6: rgb_d = 24'h0000FF;
                        default: rgb_d = 24'h000000;
                    endcase
                end
            endcase
        end
        hs_d = tap.hs;
        vs_d = tap.vs;
        de_d = tap.de && tap.run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_VS;
            vs_prev_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            mode_q      <= '0;
            frame_cnt_q <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < CSC_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            de_prev_q   <= de_prev_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < CSC_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
        end
    end

    assign o_r_8b        = rgb_q[23:16];
    assign o_g_8b        = rgb_q[15:8];
    assign o_b_8b        = rgb_q[7:0];
    assign o_h_sync      = hs_q;
    assign o_v_sync      = vs_q;
    assign o_data_en     = de_q;
    assign o_mode_active = mode_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_line_err    = line_err_q;
    assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_ycbcr2rgb_ctrl.sv
// tb/tb_ycbcr2rgb_ctrl.sv - randomized frame stimulus against a pixel-level reference of ycbcr2rgb_ctrl
module tb_ycbcr2rgb_ctrl;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int BW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_y_8b = '0, i_cb_8b = '0, i_cr_8b = '0;
    logic        i_h_sync = 1'b0, i_v_sync = 1'b0, i_data_en = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic        err_clr = 1'b0;
    logic [7:0]  csc_y_8b, csc_cb_8b, csc_cr_8b;
    logic [7:0]  csc_r_8b, csc_g_8b, csc_b_8b;
    logic [7:0]  o_r_8b, o_g_8b, o_b_8b;
    logic        o_h_sync, o_v_sync, o_data_en;
    logic [1:0]  o_mode_active;
    logic [15:0] o_frame_cnt;
    logic        o_line_err, o_frame_err;

    ycbcr2rgb_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .BAR_W(BW), .VS_POL(1'b1), .CSC_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .i_y_8b(i_y_8b), .i_cb_8b(i_cb_8b), .i_cr_8b(i_cr_8b),
        .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_data_en(i_data_en),
        .cfg_mode(cfg_mode), .err_clr(err_clr),
        .csc_y_8b(csc_y_8b), .csc_cb_8b(csc_cb_8b), .csc_cr_8b(csc_cr_8b),
        .csc_r_8b(csc_r_8b), .csc_g_8b(csc_g_8b), .csc_b_8b(csc_b_8b),
        .o_r_8b(o_r_8b), .o_g_8b(o_g_8b), .o_b_8b(o_b_8b),
        .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_data_en(o_data_en),
        .o_mode_active(o_mode_active), .o_frame_cnt(o_frame_cnt),
        .o_line_err(o_line_err), .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    // Stand-in converter: an arbitrary mapping with three cycles of latency.
    function automatic logic [23:0] conv(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        return {y ^ cr, 8'(y + cb), 8'(cr - y)};
    endfunction

    logic [23:0] cv [3] = '{24'd0, 24'd0, 24'd0};
    always @(posedge clk) begin
        cv[0] <= conv(csc_y_8b, csc_cb_8b, csc_cr_8b);
        cv[1] <= cv[0];
        cv[2] <= cv[1];
    end
    assign {csc_r_8b, csc_g_8b, csc_b_8b} = cv[2];

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    bit          m_run, m_lerr, m_ferr, m_pvs, m_pde;
    logic [1:0]  m_mode;
    logic [15:0] m_fcnt;
    int          m_pix, m_lines;
    logic [26:0] expq [$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_lerr = 0; m_ferr = 0; m_pvs = 0; m_pde = 0;
        m_mode = '0; m_fcnt = '0; m_pix = 0; m_lines = 0;
        expq = {27'd0, 27'd0, 27'd0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        err_clr = 1'b0;
        @(posedge clk); #1;
        check("reset_pix", {5'd0, o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en}, 32'd0);
        check("reset_state", {12'd0, o_mode_active, o_frame_cnt, o_line_err, o_frame_err}, 32'd0);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic cyc(input logic hs, input logic vs, input logic de,
                       input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr, input logic clr);
        logic [23:0] px;
        bit lset, fset;
        int bi;
        i_h_sync = hs; i_v_sync = vs; i_data_en = de;
        i_y_8b = y; i_cb_8b = cb; i_cr_8b = cr; err_clr = clr;
        px = '0;
        if (de && m_run) begin
            case (m_mode)
                2'd0: px = conv(y, cb, cr);
                2'd1: px = {y, cb, cr};
                2'd2: px = {y, y, y};
                default: begin
                    bi = (m_pix / BW > 7) ? 7 : m_pix / BW;
                    px = bars[bi];
                end
            endcase
        end
        expq.push_back({px, hs, vs, de && m_run});
        lset = m_pde && !de && m_run && (m_pix != H);
        fset = 0;
        if (de) m_pix++;
        if (m_pde && !de) begin
            m_lines++;
            m_pix = 0;
        end
        if (vs && !m_pvs) begin
            if (m_run) begin
                m_fcnt++;
                fset = (m_lines != V);
            end
            m_lines = 0;
            m_mode = cfg_mode;
            m_run = 1;
        end
        m_lerr = lset ? 1'b1 : (clr ? 1'b0 : m_lerr);
        m_ferr = fset ? 1'b1 : (clr ? 1'b0 : m_ferr);
        m_pvs = vs;
        m_pde = de;
        @(posedge clk); #1;
        check("pix", {5'd0, o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en}, {5'd0, expq.pop_front()});
        check("state", {12'd0, o_mode_active, o_frame_cnt, o_line_err, o_frame_err},
              {12'd0, m_mode, m_fcnt, m_lerr, m_ferr});
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0);
    endtask

    task automatic line(input int npix, input bit clr);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        pixels(npix);
        cyc(0, 0, 0, 0, 0, 0, clr);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame(input int nlines, input int short_idx, input logic [1:0] cfg_vs,
                         input logic [1:0] cfg_mid, input bit clr_short);
        cfg_mode = cfg_vs;
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int l = 0; l < nlines; l++) begin
            if (l == nlines / 2) cfg_mode = cfg_mid;
            line((l == short_idx) ? H - 1 : H, (l == short_idx) && clr_short);
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        line(H, 0);
        line(H, 0);
        frame(V, -1, 2'd1, 2'd1, 0);
        frame(V, -1, 2'd0, 2'd0, 0);
        frame(V, -1, 2'd3, 2'd3, 0);
        frame(V, -1, 2'd0, 2'd2, 0);
        frame(V, -1, 2'd2, 2'd2, 0);
        frame(V - 1, 1, 2'd0, 2'd0, 1);
        frame(V, -1, 2'd1, 2'd1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("err_cleared", {30'd0, o_line_err, o_frame_err}, 32'd0);
        frame(1, -1, 2'd3, 2'd3, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        pixels(5);
        do_reset();
        pixels(5);
        cyc(0, 0, 0, 0, 0, 0, 0);
        line(H, 0);
        frame(V, -1, 2'd2, 2'd2, 0);
        frame(V, -1, 2'd3, 2'd3, 0);
        frame(0, -1, 2'd0, 2'd0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
